// File: rtl/receptor_trafico.sv
// rtl/receptor_trafico.sv - two-port egress receiver: paced FIFO pops, per-port counts, sequence/destination checks
module receptor_trafico #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [CNT_W-1:0]  expected_D0,
  input  logic [CNT_W-1:0]  expected_D1,
  input  logic              D0_empty,
  input  logic              D1_empty,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [CNT_W-1:0]  count_D0,
  output logic [CNT_W-1:0]  count_D1,
  output logic [1:0]        seq_err,
  output logic [1:0]        dest_err,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       pop, pop_next, pend, first, empty;
  logic [CNT_W-1:0] cnt      [2];
  logic [CNT_W-1:0] expd     [2];
  logic [CNT_W:0]   inflight [2];
  logic [4:0]       word     [2];
  logic [3:0]       nxt      [2];
  logic             unused_hi;

  assign empty     = {D1_empty, D0_empty};
  assign expd[0]   = expected_D0;
  assign expd[1]   = expected_D1;
  assign word[0]   = data_out0[4:0];
  assign word[1]   = data_out1[4:0];
  assign unused_hi = ^{data_out0[DATA_W-1:5], data_out1[DATA_W-1:5]};
  assign pop_D0    = pop[0];
  assign pop_D1    = pop[1];
  assign count_D0  = cnt[0];
  assign count_D1  = cnt[1];

  always_comb begin
    state_next = state;
    pop_next   = '0;
    done       = (state == DONE);
    // A word already popped but not yet captured counts toward the target, so no extra pop is issued.
    for (int i = 0; i < 2; i++)
      inflight[i] = {1'b0, cnt[i]} + (CNT_W+1)'(pend[i]);
    case (state)
      IDLE: begin
        if (init) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (cnt[0] >= expd[0] && cnt[1] >= expd[1]) state_next = DONE;
        for (int i = 0; i < 2; i++)
          pop_next[i] = !empty[i] && !pop[i] && (inflight[i] < {1'b0, expd[i]});
      end
      default: ;
    endcase
    if (init) begin
      state_next = ACTIVE;
      pop_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pop      <= '0;
      pend     <= '0;
      first    <= 2'b11;
      seq_err  <= '0;
      dest_err <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        nxt[i] <= '0;
      end
    end else begin
      state <= state_next;
      pop   <= pop_next;
      if (init) begin
        pend     <= '0;
        first    <= 2'b11;
        seq_err  <= '0;
        dest_err <= '0;
        for (int i = 0; i < 2; i++) begin
          cnt[i] <= '0;
          nxt[i] <= '0;
        end
      end else begin
        pend <= pop;
        for (int i = 0; i < 2; i++) begin
          if (pend[i]) begin
            if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
            if (word[i][4] != i[0]) dest_err[i] <= 1'b1;
            // Always resynchronise to the received payload so one gap flags only once.
            if (!first[i] && word[i][3:0] != nxt[i]) seq_err[i] <= 1'b1;
            first[i] <= 1'b0;
            nxt[i]   <= word[i][3:0] + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor_trafico.sv
// tb/tb_receptor_trafico.sv - directed self-checking bench for receptor_trafico with behavioural egress FIFOs
module tb_receptor_trafico;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [7:0] expected_D0, expected_D1;
  logic       D0_empty, D1_empty;
  logic [5:0] data_out0 = '0, data_out1 = '0;
  logic       pop_D0, pop_D1;
  logic [7:0] count_D0, count_D1;
  logic [1:0] seq_err, dest_err;
  logic       done;

  int total = 0, passed = 0;
  logic [5:0] mem0 [0:63];
  logic [5:0] mem1 [0:63];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int pops0 = 0, b2b = 0;
  logic pop_prev = 1'b0;

  receptor_trafico #(.DATA_W(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .init(init),
    .expected_D0(expected_D0), .expected_D1(expected_D1),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .data_out0(data_out0), .data_out1(data_out1),
    .pop_D0(pop_D0), .pop_D1(pop_D1),
    .count_D0(count_D0), .count_D1(count_D1),
    .seq_err(seq_err), .dest_err(dest_err), .done(done)
  );

  always #5 clk = ~clk;

  assign D0_empty = (rd0 == wr0);
  assign D1_empty = (rd1 == wr1);

  // Registered-read FIFOs: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (pop_D0) begin
      data_out0 <= mem0[rd0];
      rd0 <= rd0 + 1;
    end
    if (pop_D1) begin
      data_out1 <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
    if (pop_D0) pops0 <= pops0 + 1;
    if (pop_D0 && pop_prev) b2b <= b2b + 1;
    pop_prev <= pop_D0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push0(input logic [5:0] v);
    mem0[wr0] = v;
    wr0++;
  endtask

  task automatic push1(input logic [5:0] v);
    mem1[wr1] = v;
    wr1++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input logic [7:0] e0, input logic [7:0] e1);
    expected_D0 = e0;
    expected_D1 = e1;
    init = 1'b1;
    step(1);
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      step(1);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_cnt0(input string tag, input logic [7:0] v);
    int n = 0;
    while (count_D0 != v && n < 100) begin
      step(1);
      n++;
    end
    chk(tag, 32'(count_D0), 32'(v));
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b0; init = 1'b0; expected_D0 = '0; expected_D1 = '0;
    step(2);
    chk("rst_pop", 32'({pop_D1, pop_D0}), 32'd0);
    chk("rst_cnt", 32'({count_D1, count_D0}), 32'd0);
    chk("rst_err", 32'({seq_err, dest_err}), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    // Basic single-port transfer; no pops while idle
    push0(6'h00); push0(6'h01); push0(6'h02); push0(6'h03);
    base = pops0;
    step(4);
    chk("idle_nopop", 32'(pops0 - base), 32'd0);
    pulse_init(8'd4, 8'd0);
    wait_done("t1_done");
    chk("t1_cnt0", 32'(count_D0), 32'd4);
    chk("t1_cnt1", 32'(count_D1), 32'd0);
    chk("t1_err", 32'({seq_err, dest_err}), 32'd0);
    chk("t1_pops", 32'(pops0 - base), 32'd4);
    step(3);
    chk("t1_done_hold", 32'(done), 32'd1);

    // Both ports, payload wrap on D0, bit5 set on D1
    push0(6'h0E); push0(6'h0F); push0(6'h00);
    push1(6'h30); push1(6'h31);
    base = pops0;
    pulse_init(8'd3, 8'd2);
    chk("t2_cleared", 32'(count_D0), 32'd0);
    wait_done("t2_done");
    chk("t2_cnt0", 32'(count_D0), 32'd3);
    chk("t2_cnt1", 32'(count_D1), 32'd2);
    chk("t2_seq", 32'(seq_err), 32'd0);
    chk("t2_dest", 32'(dest_err), 32'd0);
    chk("t2_pops", 32'(pops0 - base), 32'd3);

    // Sequence gap flagged on third word only
    push0(6'h01); push0(6'h02); push0(6'h05); push0(6'h06);
    pulse_init(8'd4, 8'd0);
    wait_cnt0("t3_cnt2", 8'd2);
    chk("t3_seq_before", 32'(seq_err), 32'd0);
    wait_cnt0("t3_cnt3", 8'd3);
    chk("t3_seq_after", 32'(seq_err), 32'd1);
    wait_done("t3_done");
    chk("t3_cnt0", 32'(count_D0), 32'd4);
    chk("t3_seq_final", 32'(seq_err), 32'd1);
    chk("t3_dest", 32'(dest_err), 32'd0);

    // Wrong destination on both ports, still counted
    push0(6'h10); push1(6'h05);
    pulse_init(8'd1, 8'd1);
    wait_done("t4_done");
    chk("t4_dest", 32'(dest_err), 32'd3);
    chk("t4_cnt0", 32'(count_D0), 32'd1);
    chk("t4_cnt1", 32'(count_D1), 32'd1);
    chk("t4_seq", 32'(seq_err), 32'd0);

    // Empty D0 never popped, never done
    base = pops0;
    pulse_init(8'd2, 8'd0);
    step(20);
    chk("t5_pops", 32'(pops0 - base), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_cnt0", 32'(count_D0), 32'd0);

    // Reset between a pop and its data cycle
    push0(6'h00); push0(6'h01);
    pulse_init(8'd3, 8'd0);
    wait_cnt0("t6_cnt1", 8'd1);
    n = 0;
    while (!pop_D0 && n < 50) begin
      step(1);
      n++;
    end
    chk("t6_pop_seen", 32'(pop_D0), 32'd1);
    step(1);
    reset = 1'b0;
    #1;
    chk("t6_rst_pop", 32'({pop_D1, pop_D0}), 32'd0);
    chk("t6_rst_cnt", 32'({count_D1, count_D0}), 32'd0);
    chk("t6_rst_err", 32'({seq_err, dest_err}), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    step(2);
    reset = 1'b1;
    push0(6'h07); push0(6'h08);
    base = pops0;
    step(4);
    chk("t6_no_count", 32'(count_D0), 32'd0);
    chk("t6_idle_nopop", 32'(pops0 - base), 32'd0);
    pulse_init(8'd2, 8'd0);
    wait_done("t6_done");
    chk("t6_cnt0", 32'(count_D0), 32'd2);
    chk("t6_err", 32'({seq_err, dest_err}), 32'd0);
    chk("pop_spacing", 32'(b2b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
